// File: rtl/key_schedule_engine_if.sv
// Key-schedule control and round-key stream bundle between a key source/consumer and the engine.
// master drives start/key and rk_ready; slave (the engine) drives status and the round-key stream.
interface key_schedule_engine_if;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy;
  logic         err;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  logic         rk_last;

  modport master (
    output start, key_len, key_in, rk_ready,
    input  busy, err, rk_valid, rk_data, rk_index, rk_last
  );

  modport slave (
    input  start, key_len, key_in, rk_ready,
    output busy, err, rk_valid, rk_data, rk_index, rk_last
  );
endinterface

// File: rtl/key_schedule_engine.sv
// Word-serial AES-128/192/256 key expansion streaming 128-bit round keys over valid/ready.
// rk0 valid 4 cycles after accept; sbox words cost 1+SBOX_LAT cycles; generation stalls while the output register is held.
module key_schedule_engine #(
  parameter bit EN_192   = 1'b1,
  parameter bit EN_256   = 1'b1,
  parameter int SBOX_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  key_schedule_engine_if.slave  ks
);

  typedef enum logic [2:0] {IDLE, KEYW, GEN, SUBW, DONE} state_t;

  localparam logic [1:0] SUB_LAST = 2'((SBOX_LAT > 0) ? SBOX_LAT - 1 : 0);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // Inverse as x^254 in GF(2^8), then the AES affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0]  inv;
    logic [7:0]  sq;
    logic [15:0] d;
    inv = 8'h01;
    sq  = x;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    d = {inv, inv};
    return inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_t       state;
  logic [255:0] key_q;
  logic [31:0]  win [8];
  logic [7:0]   rcon;
  logic [5:0]   wi;
  logic [2:0]   wj;
  logic [2:0]   nk_m1;
  logic [5:0]   last_w;
  logic [31:0]  pack [3];
  logic [1:0]   pack_cnt;
  logic [1:0]   sub_cnt;
  logic [31:0]  sub_p1;
  logic [31:0]  sub_p2;

  logic         len_ok;
  logic         need_sub;
  logic [31:0]  sub_in;
  logic [31:0]  sub_comb;
  logic [31:0]  sub_sel;
  logic [31:0]  temp;
  logic [31:0]  new_word;
  logic         produce;
  logic         out_free;
  logic         fire;
  logic         is_last;

  assign len_ok   = (ks.key_len == 2'b00) || (ks.key_len == 2'b01 && EN_192) ||
                    (ks.key_len == 2'b10 && EN_256);
  assign need_sub = (wj == 3'd0) || (nk_m1 == 3'd7 && wj == 3'd4);
  assign sub_in   = (wj == 3'd0) ? {win[0][23:0], win[0][31:24]} : win[0];
  assign sub_comb = sub_word(sub_in);
  assign sub_sel  = (SBOX_LAT == 0) ? sub_comb : (SBOX_LAT == 1) ? sub_p1 : sub_p2;
  assign temp     = !need_sub ? win[0] :
                    (wj == 3'd0) ? (sub_sel ^ {rcon, 24'h0}) : sub_sel;
  assign new_word = (state == KEYW) ? key_q[255:224] : (win[nk_m1] ^ temp);
  assign produce  = (state == KEYW) ||
                    (state == GEN && (!need_sub || SBOX_LAT == 0)) ||
                    (state == SUBW && sub_cnt == SUB_LAST);
  assign out_free = !ks.rk_valid || ks.rk_ready;
  // The 4th word of a group may only be produced if the output register can take it.
  assign fire     = produce && (pack_cnt != 2'd3 || out_free);
  assign is_last  = (wi == last_w);

  // Sbox input is held stable while waiting in SUBW, so the pipe settles on the right value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_p1 <= '0;
      sub_p2 <= '0;
    end else begin
      sub_p1 <= sub_comb;
      sub_p2 <= sub_p1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      key_q       <= '0;
      for (int k = 0; k < 8; k++) win[k] <= '0;
      for (int k = 0; k < 3; k++) pack[k] <= '0;
      rcon        <= 8'h01;
      wi          <= '0;
      wj          <= '0;
      nk_m1       <= 3'd3;
      last_w      <= 6'd43;
      pack_cnt    <= '0;
      sub_cnt     <= '0;
      ks.busy     <= 1'b0;
      ks.err      <= 1'b0;
      ks.rk_valid <= 1'b0;
      ks.rk_data  <= '0;
      ks.rk_index <= '0;
      ks.rk_last  <= 1'b0;
    end else begin
      ks.err <= 1'b0;

      if (fire) begin
        for (int k = 7; k > 0; k--) win[k] <= win[k-1];
        win[0] <= new_word;
        wi     <= wi + 6'd1;
        wj     <= (wj == nk_m1) ? 3'd0 : wj + 3'd1;
        if (state == KEYW) key_q <= key_q << 32;
        if (state != KEYW && wj == 3'd0) rcon <= xt(rcon);
        if (pack_cnt == 2'd3) pack_cnt <= 2'd0;
        else begin
          pack[pack_cnt] <= new_word;
          pack_cnt       <= pack_cnt + 2'd1;
        end
      end

      if (fire && pack_cnt == 2'd3) begin
        ks.rk_valid <= 1'b1;
        ks.rk_data  <= {pack[0], pack[1], pack[2], new_word};
        ks.rk_index <= wi[5:2];
        ks.rk_last  <= is_last;
      end else if (ks.rk_valid && ks.rk_ready) begin
        ks.rk_valid <= 1'b0;
        ks.rk_last  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ks.start) begin
            if (len_ok) begin
              state    <= KEYW;
              ks.busy  <= 1'b1;
              key_q    <= ks.key_in;
              rcon     <= 8'h01;
              wi       <= '0;
              wj       <= '0;
              pack_cnt <= '0;
              case (ks.key_len)
                2'b01:   begin nk_m1 <= 3'd5; last_w <= 6'd51; end
                2'b10:   begin nk_m1 <= 3'd7; last_w <= 6'd59; end
                default: begin nk_m1 <= 3'd3; last_w <= 6'd43; end
              endcase
            end else begin
              ks.err <= 1'b1;
            end
          end
        end
        KEYW: begin
          if (fire && wj == nk_m1) state <= GEN;
        end
        GEN: begin
          if (fire) begin
            if (is_last) state <= DONE;
          end else if (need_sub && SBOX_LAT > 0) begin
            state   <= SUBW;
            sub_cnt <= 2'd0;
          end
        end
        SUBW: begin
          if (sub_cnt != SUB_LAST) sub_cnt <= sub_cnt + 2'd1;
          else if (fire) state <= is_last ? DONE : GEN;
        end
        DONE: begin
          if (ks.rk_valid && ks.rk_ready && ks.rk_last) begin
            state   <= IDLE;
            ks.busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_schedule_engine.sv
// Directed bench for key_schedule_engine: FIPS-197 expansions, latency, back-pressure, err, mid-run reset.
module tb_key_schedule_engine;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  key_schedule_engine_if bus();

  key_schedule_engine #(.EN_192(1'b1), .EN_256(1'b1), .SBOX_LAT(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ks    (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [127:0] got_d [16];
  logic [3:0]   got_i [16];
  logic         got_l [16];
  int           nkeys, first_cyc, last_cyc, stable_err, err_seen;
  bit           timeout;
  logic [127:0] exp128 [11];

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start one run and collect handshaken keys; a stray start (illegal length) is injected while busy.
  task automatic run_key(input logic [1:0] kl, input logic [255:0] key, input int pct,
                         input int stop_after);
    int           cyc;
    bit           stalled, done;
    logic [127:0] hd;
    logic [3:0]   hi;
    logic         hl;
    nkeys = 0; first_cyc = -1; last_cyc = -1; stable_err = 0; err_seen = 0; timeout = 0;
    stalled = 0; done = 0; hd = '0; hi = '0; hl = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.key_len = kl; bus.key_in = key; bus.rk_ready = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.key_in = '1; bus.key_len = 2'b11;
    cyc = 0;
    while (!done && cyc < 600) begin
      if (bus.err) err_seen++;
      if (stalled && (!bus.rk_valid || bus.rk_data !== hd || bus.rk_index !== hi ||
                      bus.rk_last !== hl)) stable_err++;
      if (bus.rk_valid && first_cyc < 0) first_cyc = cyc;
      if (bus.rk_valid && bus.rk_last && last_cyc < 0) last_cyc = cyc;
      bus.start    = (cyc == 10);
      bus.rk_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      stalled = bus.rk_valid && !bus.rk_ready;
      hd = bus.rk_data; hi = bus.rk_index; hl = bus.rk_last;
      if (bus.rk_valid && bus.rk_ready) begin
        if (nkeys < 16) begin
          got_d[nkeys] = bus.rk_data;
          got_i[nkeys] = bus.rk_index;
          got_l[nkeys] = bus.rk_last;
        end
        nkeys++;
        if (bus.rk_last || nkeys == stop_after) done = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0; bus.rk_ready = 1'b0;
    if (!done) timeout = 1;
  endtask

  task automatic check_128(input string tag);
    chk({tag, "_timeout"}, 128'(timeout), 128'd0);
    chk({tag, "_nkeys"}, 128'(nkeys), 128'd11);
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("%s_rk%0d", tag, k), got_d[k], exp128[k]);
      chk($sformatf("%s_idx%0d", tag, k), 128'(got_i[k]), 128'(k));
    end
    chk({tag, "_last10"}, 128'(got_l[10]), 128'd1);
    chk({tag, "_last9"}, 128'(got_l[9]), 128'd0);
    chk({tag, "_stable"}, 128'(stable_err), 128'd0);
    chk({tag, "_no_err"}, 128'(err_seen), 128'd0);
    chk({tag, "_busy_end"}, 128'(bus.busy), 128'd0);
  endtask

  initial begin
    int vld_seen;
    exp128[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp128[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp128[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp128[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp128[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp128[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp128[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp128[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp128[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp128[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp128[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.key_len = 2'b00; bus.key_in = '0; bus.rk_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_err", 128'(bus.err), 128'd0);
    chk("rst_valid", 128'(bus.rk_valid), 128'd0);
    chk("rst_last", 128'(bus.rk_last), 128'd0);
    chk("rst_data", bus.rk_data, 128'd0);
    chk("rst_index", 128'(bus.rk_index), 128'd0);
    rst_n = 1'b1;

    // AES-128, ready held high
    run_key(2'b00, KEY128, 100, 0);
    check_128("t1");
    chk("t1_first_cyc", 128'(first_cyc), 128'd4);
    chk("t1_last_cyc", 128'(last_cyc), 128'd54);

    // AES-192
    run_key(2'b01, KEY192, 100, 0);
    chk("t2_timeout", 128'(timeout), 128'd0);
    chk("t2_nkeys", 128'(nkeys), 128'd13);
    chk("t2_rk0", got_d[0], 128'h8e73b0f7da0e6452c810f32b809079e5);
    chk("t2_rk1", got_d[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    chk("t2_rk12", got_d[12], 128'he98ba06f448c773c8ecc720401002202);
    chk("t2_idx12", 128'(got_i[12]), 128'd12);
    chk("t2_last12", 128'(got_l[12]), 128'd1);
    chk("t2_last_cyc", 128'(last_cyc), 128'd60);
    chk("t2_busy_end", 128'(bus.busy), 128'd0);

    // AES-256
    run_key(2'b10, KEY256, 100, 0);
    chk("t3_timeout", 128'(timeout), 128'd0);
    chk("t3_nkeys", 128'(nkeys), 128'd15);
    chk("t3_rk0", got_d[0], 128'h603deb1015ca71be2b73aef0857d7781);
    chk("t3_rk1", got_d[1], 128'h1f352c073b6108d72d9810a30914dff4);
    chk("t3_rk14", got_d[14], 128'hfe4890d1e6188d0b046df344706c631e);
    chk("t3_idx14", 128'(got_i[14]), 128'd14);
    chk("t3_last14", 128'(got_l[14]), 128'd1);
    chk("t3_first_cyc", 128'(first_cyc), 128'd4);
    chk("t3_last_cyc", 128'(last_cyc), 128'd73);

    // AES-128 under random back-pressure
    run_key(2'b00, KEY128, 30, 0);
    check_128("t4");

    // Illegal key length
    @(posedge clk); #1;
    bus.start = 1'b1; bus.key_len = 2'b11; bus.key_in = KEY128;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("t5_err_pulse", 128'(bus.err), 128'd1);
    chk("t5_busy", 128'(bus.busy), 128'd0);
    @(posedge clk); #1;
    chk("t5_err_clear", 128'(bus.err), 128'd0);
    vld_seen = 0;
    bus.rk_ready = 1'b1;
    repeat (8) begin
      if (bus.rk_valid || bus.busy) vld_seen++;
      @(posedge clk); #1;
    end
    bus.rk_ready = 1'b0;
    chk("t5_no_valid", 128'(vld_seen), 128'd0);

    // Reset after rk3 accepted, then a fresh run
    run_key(2'b00, KEY128, 100, 4);
    chk("t6_partial_keys", 128'(nkeys), 128'd4);
    chk("t6_rk3", got_d[3], exp128[3]);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_valid", 128'(bus.rk_valid), 128'd0);
    chk("t6_rst_busy", 128'(bus.busy), 128'd0);
    chk("t6_rst_data", bus.rk_data, 128'd0);
    chk("t6_rst_index", 128'(bus.rk_index), 128'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    vld_seen = 0;
    bus.rk_ready = 1'b1;
    repeat (10) begin
      if (bus.rk_valid || bus.busy) vld_seen++;
      @(posedge clk); #1;
    end
    bus.rk_ready = 1'b0;
    chk("t6_no_leftover", 128'(vld_seen), 128'd0);
    run_key(2'b00, KEY128, 100, 0);
    check_128("t6");
    chk("t6_first_cyc", 128'(first_cyc), 128'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
